// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 sequencer.
package arc4_pkg;

  // Default per-phase cycle budget before the sequencer gives up.
  localparam int unsigned DefaultTimeout = 4096;

  typedef enum logic [3:0] {
    StBoot,
    StIdle,
    StInitGo,
    StInitWait,
    StKsaGo,
    StKsaWait,
    StPrgaGo,
    StPrgaWait,
    StErr
  } seq_state_t;

  typedef enum logic [1:0] {
    PhaseNone = 2'd0,
    PhaseInit = 2'd1,
    PhaseKsa  = 2'd2,
    PhasePrga = 2'd3
  } phase_t;

  // Which sub-block owns the S-memory port in a given state.
  function automatic phase_t state_phase(input seq_state_t s);
    case (s)
      StInitGo, StInitWait: return PhaseInit;
      StKsaGo, StKsaWait:   return PhaseKsa;
      StPrgaGo, StPrgaWait: return PhasePrga;
      default:              return PhaseNone;
    endcase
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; flags when the phase has used its whole budget.
module phase_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Clear wins over increment so a phase entry always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/arc4_seq.sv
// ARC4 top-level sequencer: runs init, ksa, prga in order, owns the S-memory port,
// supervises each phase with a watchdog and flags foreign writes.
module arc4_seq
  import arc4_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic       err,
  output logic       viol,
  output logic [1:0] phase,
  output logic       init_en,
  output logic       ksa_en,
  output logic       prga_en,
  input  logic       init_rdy,
  input  logic       ksa_rdy,
  input  logic       prga_rdy,
  input  logic [7:0] init_addr,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] prga_addr,
  input  logic [7:0] init_wrdata,
  input  logic [7:0] ksa_wrdata,
  input  logic [7:0] prga_wrdata,
  input  logic       init_wren,
  input  logic       ksa_wren,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  seq_state_t state_q, state_d;
  phase_t     cur_ph;
  logic       rdy_q, err_q, viol_q, seen_low_q;
  logic       own_rdy, vio_now;
  logic       wd_clr, wd_inc, wd_exp;
  logic       in_wait;

  assign cur_ph  = state_phase(state_q);
  assign phase   = cur_ph;
  assign rdy     = rdy_q;
  assign err     = err_q;
  assign viol    = viol_q;
  assign in_wait = (state_q == StInitWait) || (state_q == StKsaWait) || (state_q == StPrgaWait);

  // A start pulse is only offered while the target block says it can take it.
  assign init_en = (state_q == StInitGo) && init_rdy;
  assign ksa_en  = (state_q == StKsaGo) && ksa_rdy;
  assign prga_en = (state_q == StPrgaGo) && prga_rdy;

  // Owner mux for the S port plus detection of writes from any non-owner.
  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    own_rdy  = 1'b0;
    vio_now  = 1'b0;
    unique case (cur_ph)
      PhaseInit: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
        own_rdy  = init_rdy;
        vio_now  = ksa_wren | prga_wren;
      end
      PhaseKsa: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
        own_rdy  = ksa_rdy;
        vio_now  = init_wren | prga_wren;
      end
      PhasePrga: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
        own_rdy  = prga_rdy;
        vio_now  = init_wren | ksa_wren;
      end
      PhaseNone: begin
        // Once in error nobody is supervised any more.
        vio_now = (state_q != StErr) && (init_wren | ksa_wren | prga_wren);
      end
    endcase
  end

  // Next-state logic; in GO a timeout beats the handshake so the counter can never
  // run past its compare value, in WAIT completion beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:     state_d = StIdle;
      StIdle:     if (en) state_d = StInitGo;
      StInitGo:   if (wd_exp) state_d = StErr; else if (own_rdy) state_d = StInitWait;
      StInitWait: if (own_rdy && seen_low_q) state_d = StKsaGo; else if (wd_exp) state_d = StErr;
      StKsaGo:    if (wd_exp) state_d = StErr; else if (own_rdy) state_d = StKsaWait;
      StKsaWait:  if (own_rdy && seen_low_q) state_d = StPrgaGo; else if (wd_exp) state_d = StErr;
      StPrgaGo:   if (wd_exp) state_d = StErr; else if (own_rdy) state_d = StPrgaWait;
      StPrgaWait: if (own_rdy && seen_low_q) state_d = StIdle; else if (wd_exp) state_d = StErr;
      StErr:      state_d = StErr;
      default:    state_d = StErr;
    endcase
  end

  // Watchdog restarts on every GO entry and runs through GO and WAIT.
  always_comb begin
    wd_inc = (cur_ph != PhaseNone);
    wd_clr = (state_d != state_q) &&
             ((state_d == StInitGo) || (state_d == StKsaGo) || (state_d == StPrgaGo));
  end

  phase_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_exp)
  );

  // FSM state with registered status outputs; seen_low guards against taking the
  // stale ready level left over from the GO handshake as completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBoot;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      viol_q     <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == StIdle);
      err_q   <= (state_d == StErr);
      viol_q  <= viol_q | vio_now;
      if (state_d != state_q) begin
        seen_low_q <= 1'b0;
      end else if (in_wait && !own_rdy) begin
        seen_low_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arc4_seq.sv
// Bench for arc4_seq: behavioural sub-block stubs, S-port scoreboard, and a second
// instance with a short budget whose ksa stub never finishes.
module tb_arc4_seq;

  logic       clk, rst, en;
  logic       rdy, err, viol, init_en, ksa_en, prga_en, s_wren;
  logic [1:0] phase;
  logic [7:0] s_addr, s_wrdata;
  logic       init_rdy, ksa_rdy, prga_rdy, ksa_rdy_to;
  logic [7:0] init_addr, ksa_addr, prga_addr, init_wrdata, ksa_wrdata, prga_wrdata;
  logic       init_wren, ksa_wren, prga_wren;

  logic       rdy2, err2, viol2, init_en2, ksa_en2, prga_en2, s_wren2;
  logic [1:0] phase2;
  logic [7:0] s_addr2, s_wrdata2;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [18:0] sb[$];
  logic [18:0] exp_v;

  arc4_seq u_dut (
    .clk (clk), .rst (rst), .en (en), .rdy (rdy), .err (err), .viol (viol), .phase (phase),
    .init_en (init_en), .ksa_en (ksa_en), .prga_en (prga_en),
    .init_rdy (init_rdy), .ksa_rdy (ksa_rdy), .prga_rdy (prga_rdy),
    .init_addr (init_addr), .ksa_addr (ksa_addr), .prga_addr (prga_addr),
    .init_wrdata (init_wrdata), .ksa_wrdata (ksa_wrdata), .prga_wrdata (prga_wrdata),
    .init_wren (init_wren), .ksa_wren (ksa_wren), .prga_wren (prga_wren),
    .s_addr (s_addr), .s_wrdata (s_wrdata), .s_wren (s_wren)
  );

  arc4_seq #(.TIMEOUT (64)) u_dut_to (
    .clk (clk), .rst (rst), .en (en), .rdy (rdy2), .err (err2), .viol (viol2), .phase (phase2),
    .init_en (init_en2), .ksa_en (ksa_en2), .prga_en (prga_en2),
    .init_rdy (init_rdy), .ksa_rdy (ksa_rdy_to), .prga_rdy (prga_rdy),
    .init_addr (init_addr), .ksa_addr (ksa_addr), .prga_addr (prga_addr),
    .init_wrdata (init_wrdata), .ksa_wrdata (ksa_wrdata), .prga_wrdata (prga_wrdata),
    .init_wren (init_wren), .ksa_wren (ksa_wren), .prga_wren (prga_wren),
    .s_addr (s_addr2), .s_wrdata (s_wrdata2), .s_wren (s_wren2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] rst_vec();
    return 32'({rdy, err, viol, phase, s_addr, s_wrdata, s_wren, init_en, ksa_en, prga_en});
  endfunction

  function automatic logic en_of(input int ph);
    case (ph)
      1:       return init_en;
      2:       return ksa_en;
      default: return prga_en;
    endcase
  endfunction

  task automatic set_rdy(input int ph, input logic v);
    case (ph)
      1:       init_rdy = v;
      2:       ksa_rdy  = v;
      default: prga_rdy = v;
    endcase
  endtask

  task automatic set_bus(input int ph, input logic [7:0] a, input logic [7:0] d, input logic w);
    case (ph)
      1:       begin init_addr = a; init_wrdata = d; init_wren = w; end
      2:       begin ksa_addr  = a; ksa_wrdata  = d; ksa_wren  = w; end
      default: begin prga_addr = a; prga_wrdata = d; prga_wren = w; end
    endcase
  endtask

  // Stub for one phase: optional busy cycles, GO handshake, n write cycles, then ready.
  task automatic drive_phase(input int ph, input int n, input int busy, input bit inject,
                             input int abort_at);
    logic [7:0] a, d;
    logic       w;
    if (busy > 0) set_rdy(ph, 1'b0);
    for (int b = 0; b < busy; b++) begin
      @(negedge clk);
      check_eq("busy_no_en", 32'(en_of(ph)), 32'd0);
      @(posedge clk); #1;
    end
    set_rdy(ph, 1'b1);
    @(negedge clk);
    check_eq("go_en", 32'(en_of(ph)), 32'd1);
    check_eq("go_phase", 32'(phase), 32'(ph));
    @(posedge clk); #1;
    set_rdy(ph, 1'b0);
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1 check_eq("async_rst", rst_vec(), 32'd0);
        return;
      end
      a = (ph == 1) ? 8'(i) : 8'(i * 7 + ph);
      d = 8'(i + ph * 40);
      w = (ph == 1) ? 1'b1 : 1'(i);
      set_bus(ph, a, d, w);
      if (inject && i == 8) begin
        init_wren = 1'b1; init_addr = 8'haa; init_wrdata = 8'h55;
      end
      if (inject && i == 9) begin
        init_wren = 1'b0; init_addr = 8'h00; init_wrdata = 8'h00;
      end
      sb.push_back({2'(ph), a, d, w});
      @(negedge clk);
      if (i == 0) check_eq("en_pulse_len", 32'(en_of(ph)), 32'd0);
      if (inject && i == 8) check_eq("viol_before", 32'(viol), 32'd0);
      if (inject && i == 9) check_eq("viol_after", 32'(viol), 32'd1);
      @(posedge clk); #1;
    end
    set_bus(ph, 8'h00, 8'h00, 1'b0);
    set_rdy(ph, 1'b1);
    sb.push_back({2'(ph), 8'h00, 8'h00, 1'b0});
    @(posedge clk); #1;
  endtask

  // S-port scoreboard: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      check_eq("s_port", 32'({phase, s_addr, s_wrdata, s_wren}), 32'(exp_v));
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  wn;
    bit  wseen;
    rst = 1'b1; en = 1'b0;
    init_rdy = 1'b1; ksa_rdy = 1'b1; prga_rdy = 1'b1; ksa_rdy_to = 1'b1;
    set_bus(1, 8'h00, 8'h00, 1'b0);
    set_bus(2, 8'h00, 8'h00, 1'b0);
    set_bus(3, 8'h00, 8'h00, 1'b0);

    repeat (10) begin
      @(negedge clk);
      check_eq("rst_hold", rst_vec(), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); check_eq("boot_rdy", 32'(rdy), 32'd0);
    @(negedge clk); check_eq("idle_rdy", 32'(rdy), 32'd1);

    // Short-budget instance: ksa never comes back, expect error 64 cycles after KSA_GO.
    fork
      begin
        wseen = 1'b0;
        for (int k = 0; k < 4000 && !wseen; k++) begin
          @(negedge clk);
          if (phase2 == 2'd2) wseen = 1'b1;
        end
        check_eq("to_ksa_go", 32'(wseen), 32'd1);
        check_eq("to_ksa_en", 32'(ksa_en2), 32'd1);
        @(posedge clk); #1 ksa_rdy_to = 1'b0;
        wn = 0;
        while (!err2 && wn < 200) begin
          @(negedge clk);
          wn++;
        end
        check_eq("to_cycles", 32'(wn), 32'd64);
        check_eq("to_rdy_phase", 32'({rdy2, phase2}), 32'd0);
      end
    join_none

    // Run A: init busy at start, en held meanwhile (ignored), clean full run.
    @(posedge clk); #1 init_rdy = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    check_eq("rdy_fall", 32'(rdy), 32'd0);
    drive_phase(1, 256, 5, 1'b0, -1);
    drive_phase(2, 768, 0, 1'b0, -1);
    drive_phase(3, 300, 0, 1'b0, -1);
    @(negedge clk);
    check_eq("runA_done", 32'({rdy, err, viol, phase}), 32'b10000);

    // Run B: immediate start, foreign init write during ksa.
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    drive_phase(1, 256, 0, 1'b0, -1);
    drive_phase(2, 768, 0, 1'b1, -1);
    drive_phase(3, 300, 0, 1'b0, -1);
    @(negedge clk);
    check_eq("runB_done", 32'({rdy, err, viol, phase}), 32'b10100);
    check_eq("to_held", 32'({err2, rdy2, viol2, phase2, s_addr2, s_wrdata2, s_wren2,
                             init_en2, prga_en2}), 32'h1 << 23);

    // Run C: reset in the middle of prga.
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    drive_phase(1, 16, 0, 1'b0, -1);
    drive_phase(2, 16, 0, 1'b0, -1);
    drive_phase(3, 300, 0, 1'b0, 50);
    set_bus(3, 8'h00, 8'h00, 1'b0);
    prga_rdy = 1'b1; ksa_rdy_to = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_mid", rst_vec(), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); check_eq("reboot_rdy", 32'(rdy), 32'd0);
    @(negedge clk); check_eq("reidle", 32'({rdy, err, viol, phase}), 32'b10000);

    // Run D: restart goes back to init.
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    drive_phase(1, 8, 0, 1'b0, -1);
    drive_phase(2, 8, 0, 1'b0, -1);
    drive_phase(3, 8, 0, 1'b0, -1);
    @(negedge clk);
    check_eq("runD_done", 32'({rdy, err, viol, phase}), 32'b10000);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
